ahb_master: RTL and testbench
=============================

AHB_MASTER -- requirements
Module: ahb_master

Interface
REQ-001 SHALL have port Hclk, input, 1, single clock; all state updates on rising edge.
REQ-002 SHALL have port Hresetn, input, 1, reset, asynchronous, active-low.
REQ-003 SHALL have port cmd_valid, input, 1, command request.
REQ-004 SHALL have port cmd_ready, output, 1, command accepted when cmd_valid && cmd_ready at a rising edge.
REQ-005 SHALL have port cmd_write, input, 1, 1 = write, 0 = read.
REQ-006 SHALL have port cmd_addr, input, 32, start address, word aligned ([1:0]==0).
REQ-007 SHALL have port cmd_len, input, 2, beats minus one (1..4 beats).
REQ-008 SHALL have port wdata_in, input, 32, write beat data, sampled when wdata_req=1.
REQ-009 SHALL have port wdata_req, output, 1, one-cycle pop strobe for next write beat.
REQ-010 SHALL have ports Haddr, output, 32 and Htrans, output, 2 and Hwrite, output, 1 and Hwdata, output, 32, AHB master outputs.
REQ-011 SHALL have ports Hreadyout, input, 1 and Hresp, input, 2 and Hrdata, input, 32, AHB slave responses.
REQ-012 SHALL have ports rd_data, output, 32 and rd_valid, output, 1, read beat return.
REQ-013 SHALL have ports err, output, 1 (one-cycle ERROR pulse) and busy, output, 1 (transfer in progress).

Function
REQ-014 SHALL implement FSM states IDLE, NONSEQ, SEQ, LAST_DATA.
REQ-015 SHALL assert cmd_ready only in IDLE with no data phase pending.
REQ-016 SHALL, on command acceptance at edge N, drive Htrans=2'b10, Haddr=cmd_addr and Hwrite=cmd_write from edge N to edge N+1.
REQ-017 SHALL advance the address phase only at an edge where Hreadyout=1; while Hreadyout=0 it SHALL hold Haddr, Htrans, Hwrite and Hwdata stable.
REQ-018 SHALL drive Htrans=2'b11 (SEQ) for beats 2..cmd_len+1, with Haddr incremented by 4 per beat, modulo 2^32.
REQ-019 SHALL drive Htrans=2'b00 in LAST_DATA and IDLE, and SHALL never drive BUSY (2'b01).
REQ-020 SHALL, for a write beat whose address phase completes, pulse wdata_req in that cycle and register wdata_in onto Hwdata for the following data phase.
REQ-021 SHALL, for a read beat whose data phase completes with Hreadyout=1 and Hresp=2'b00, register Hrdata into rd_data and pulse rd_valid for one cycle on the next cycle.
REQ-022 SHALL, on Hresp=2'b01 in any data phase, pulse err, drive Htrans=IDLE for all remaining beats, suppress rd_valid for that beat, and return to IDLE once the pending data phase completes.
REQ-023 SHALL assert busy from command acceptance until the last data phase completes.
REQ-024 SHALL issue beats of back-to-back commands with at least one IDLE cycle between them.

Reset
REQ-025 SHALL, while Hresetn=0 (immediately, independent of clock), force FSM=IDLE, Htrans=2'b00, Haddr=0, Hwrite=0, Hwdata=0, rd_data=0, rd_valid=0, wdata_req=0, err=0, busy=0, cmd_ready=0.
REQ-026 SHALL, when reset is asserted mid-burst, abandon the burst with no err, rd_valid or wdata_req pulse, and set cmd_ready=1 on the first edge after deassertion.

Structure
REQ-027 SHALL take HTRANS codes (IDLE/BUSY/NONSEQ/SEQ), HRESP codes (OKAY/ERROR), the FSM state encoding and the peripheral address map constants (0x8000_0000, 0x8400_0000, 0x8800_0000, 0x8C00_0000) from shared package ahb_pkg.
REQ-028 SHALL be a single module with no sub-modules; beat counter and data-phase tracker are internal.

Verification
REQ-029 Bench SHALL cover: write to 0x8000_0000, len 0, data 0xA5A5_A5A5, Hreadyout=1 -> NONSEQ for 1 cycle, Hwdata=0xA5A5_A5A5 next cycle, wdata_req one pulse.
REQ-030 Bench SHALL cover: read from 0x8400_0000, len 3, Hreadyout=0 for 2 cycles on beat 2 -> Haddr 0x8400_0000/04/08/0C, Htrans NONSEQ,SEQ,SEQ,SEQ held stable during the wait, 4 rd_valid pulses in order.
REQ-031 Bench SHALL cover: write burst len 3 from 0x8800_0000 with Hresp=ERROR on beat 2 -> err one pulse, Htrans=IDLE afterwards, beats 3-4 never issued.
REQ-032 Bench SHALL cover: Hresetn low during beat 3 of a 4-beat read -> outputs reset immediately, no rd_valid, cmd_ready=1 one edge after release.
REQ-033 Bench SHALL cover: two back-to-back single reads with cmd_valid held high -> at least one IDLE cycle between NONSEQs, busy high during each.
REQ-034 Bench SHALL cover: start address 0xFFFF_FFFC, len 1 -> second beat address 0x0000_0000.

Source files
------------

// File: rtl/ahb_pkg.sv
// Shared AHB definitions for the master and its users.
//   - HTRANS / HRESP encodings
//   - master FSM state encoding
//   - peripheral address map
//   - helper to step an incrementing burst address
package ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_t;

    typedef enum logic [1:0] {
        HRESP_OKAY  = 2'b00,
        HRESP_ERROR = 2'b01
    } hresp_t;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'b00,
        ST_NONSEQ    = 2'b01,
        ST_SEQ       = 2'b10,
        ST_LAST_DATA = 2'b11
    } state_t;

    localparam logic [31:0] PERIPH0_BASE = 32'h8000_0000;
    localparam logic [31:0] PERIPH1_BASE = 32'h8400_0000;
    localparam logic [31:0] PERIPH2_BASE = 32'h8800_0000;
    localparam logic [31:0] PERIPH3_BASE = 32'h8C00_0000;

    localparam logic [31:0] BEAT_BYTES = 32'd4;

    // Word-incrementing burst address; wraps naturally at 2^32.
    function automatic logic [31:0] next_beat_addr(input logic [31:0] addr);
        return addr + BEAT_BYTES;
    endfunction

endpackage

// File: rtl/ahb_master.sv
// ahb_master: simple AHB-Lite burst master driven by a command interface.
//
// Ports
//   Hclk, Hresetn            clock, asynchronous active-low reset
//   cmd_valid/cmd_ready      command handshake (accepted when both high at an edge)
//   cmd_write, cmd_addr,     direction, word-aligned start address,
//   cmd_len                  beats minus one (1..4 beats, incrementing)
//   wdata_in, wdata_req      write data source; wdata_req pops one beat
//   Haddr, Htrans, Hwrite,   AHB address/control and write data
//   Hwdata
//   Hreadyout, Hresp, Hrdata AHB slave response
//   rd_data, rd_valid        read beat return (one-cycle strobe per beat)
//   err                      one-cycle pulse when a slave ERROR is seen
//   busy                     high from command acceptance to last data phase
module ahb_master
    import ahb_pkg::*;
(
    input  logic        Hclk,
    input  logic        Hresetn,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [1:0]  cmd_len,
    input  logic [31:0] wdata_in,
    output logic        wdata_req,
    output logic [31:0] Haddr,
    output logic [1:0]  Htrans,
    output logic        Hwrite,
    output logic [31:0] Hwdata,
    input  logic        Hreadyout,
    input  logic [1:0]  Hresp,
    input  logic [31:0] Hrdata,
    output logic [31:0] rd_data,
    output logic        rd_valid,
    output logic        err,
    output logic        busy
);

    state_t      state_reg;
    state_t      state_next;
    htrans_t     htrans_c;

    logic [31:0] haddr_reg;
    logic        hwrite_reg;
    logic [31:0] hwdata_reg;
    logic [1:0]  beats_left_reg;

    // Data-phase tracker: one outstanding data phase behind the address phase.
    logic        dphase_valid_reg;
    logic        dphase_write_reg;
    logic        dphase_err_reg;   // ERROR already reported for this data phase

    logic [31:0] rd_data_reg;
    logic        rd_valid_reg;
    logic        err_reg;
    // Keeps cmd_ready low until the first edge after reset is released.
    logic        out_of_reset_reg;

    logic        addr_active;
    logic        err_now;
    logic        dphase_done;
    logic        addr_done;
    logic        cmd_ready_c;
    logic        accept;

    assign addr_active = (state_reg == ST_NONSEQ) || (state_reg == ST_SEQ);
    assign err_now     = dphase_valid_reg && (Hresp == HRESP_ERROR) && !dphase_err_reg;
    assign dphase_done = dphase_valid_reg && Hreadyout;
    // An ERROR cancels the address phase in flight so later beats never issue.
    assign addr_done   = addr_active && Hreadyout && !err_now;
    assign cmd_ready_c = (state_reg == ST_IDLE) && !dphase_valid_reg && out_of_reset_reg;
    assign accept      = cmd_valid && cmd_ready_c;

    assign cmd_ready = cmd_ready_c;
    assign wdata_req = addr_done && hwrite_reg;
    assign busy      = (state_reg != ST_IDLE);
    assign Htrans    = htrans_c;
    assign Haddr     = haddr_reg;
    assign Hwrite    = hwrite_reg;
    assign Hwdata    = hwdata_reg;
    assign rd_data   = rd_data_reg;
    assign rd_valid  = rd_valid_reg;
    assign err       = err_reg;

    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        htrans_c   = HTRANS_IDLE;
        case (state_reg)
            ST_IDLE: begin
                if (accept) begin
                    state_next = ST_NONSEQ;
                end
            end
            ST_NONSEQ, ST_SEQ: begin
                htrans_c = (state_reg == ST_NONSEQ) ? HTRANS_NONSEQ : HTRANS_SEQ;
                if (err_now) begin
                    // Abort: only the erroring data phase is left to finish.
                    state_next = Hreadyout ? ST_IDLE : ST_LAST_DATA;
                end else if (Hreadyout) begin
                    state_next = (beats_left_reg == 2'd0) ? ST_LAST_DATA : ST_SEQ;
                end
            end
            ST_LAST_DATA: begin
                if (Hreadyout) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            haddr_reg        <= 32'd0;
            hwrite_reg       <= 1'b0;
            hwdata_reg       <= 32'd0;
            beats_left_reg   <= 2'd0;
            dphase_valid_reg <= 1'b0;
            dphase_write_reg <= 1'b0;
            dphase_err_reg   <= 1'b0;
            rd_data_reg      <= 32'd0;
            rd_valid_reg     <= 1'b0;
            err_reg          <= 1'b0;
            out_of_reset_reg <= 1'b0;
        end else begin
            out_of_reset_reg <= 1'b1;
            err_reg          <= err_now;
            rd_valid_reg     <= 1'b0;

            if (accept) begin
                haddr_reg      <= cmd_addr;
                hwrite_reg     <= cmd_write;
                beats_left_reg <= cmd_len;
            end else if (addr_done && (beats_left_reg != 2'd0)) begin
                haddr_reg      <= next_beat_addr(haddr_reg);
                beats_left_reg <= beats_left_reg - 2'd1;
            end

            if (dphase_done && !dphase_write_reg && !dphase_err_reg
                && (Hresp == HRESP_OKAY)) begin
                rd_data_reg  <= Hrdata;
                rd_valid_reg <= 1'b1;
            end

            if (addr_done) begin
                dphase_valid_reg <= 1'b1;
                dphase_write_reg <= hwrite_reg;
                dphase_err_reg   <= 1'b0;
                if (hwrite_reg) begin
                    hwdata_reg <= wdata_in;
                end
            end else if (dphase_done) begin
                dphase_valid_reg <= 1'b0;
                dphase_err_reg   <= 1'b0;
            end else if (err_now) begin
                dphase_err_reg <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ahb_master.sv
module tb_ahb_master;

    logic        Hclk;
    logic        Hresetn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [1:0]  cmd_len;
    logic [31:0] wdata_in;
    logic        wdata_req;
    logic [31:0] Haddr;
    logic [1:0]  Htrans;
    logic        Hwrite;
    logic [31:0] Hwdata;
    logic        Hreadyout;
    logic [1:0]  Hresp;
    logic [31:0] Hrdata;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        err;
    logic        busy;

    int check_cnt = 0;
    int fail_cnt  = 0;

    // bus monitor state
    logic [31:0] addr_q[$];
    logic [1:0]  trans_q[$];
    logic [31:0] rd_q[$];
    int wreq_cnt, err_pulses, nonseq_cyc, post_err_active;
    int min_gap, idle_run;
    bit seen_nonseq, seen_err;
    int trans_busy_cnt = 0;
    int busy_viol = 0;
    bit prev_stall;
    logic [31:0] prev_addr, prev_wdata;
    logic [1:0]  prev_trans;
    bit busy_s, acc_s;

    // slave model state
    int stall_beat, stall_left, err_beat;
    bit err_phase;
    bit dp_active, dp_write;
    logic [31:0] dp_addr, dp_wdata;
    int dp_beat, beat_cnt;

    assign Hrdata = dp_addr ^ 32'h5A5A_0000;

    ahb_master dut (
        .Hclk      (Hclk),
        .Hresetn   (Hresetn),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_len   (cmd_len),
        .wdata_in  (wdata_in),
        .wdata_req (wdata_req),
        .Haddr     (Haddr),
        .Htrans    (Htrans),
        .Hwrite    (Hwrite),
        .Hwdata    (Hwdata),
        .Hreadyout (Hreadyout),
        .Hresp     (Hresp),
        .Hrdata    (Hrdata),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .err       (err),
        .busy      (busy)
    );

    initial Hclk = 1'b0;
    always #5 Hclk = ~Hclk;

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        check_cnt++;
        if (obs !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] addr_at(input int i);
        return (i < addr_q.size()) ? addr_q[i] : 32'hDEAD_BEEF;
    endfunction

    function automatic logic [31:0] trans_at(input int i);
        return (i < trans_q.size()) ? 32'(trans_q[i]) : 32'hDEAD_BEEF;
    endfunction

    function automatic logic [31:0] rd_at(input int i);
        return (i < rd_q.size()) ? rd_q[i] : 32'hDEAD_BEEF;
    endfunction

    task automatic clear_mon();
        addr_q.delete();
        trans_q.delete();
        rd_q.delete();
        wreq_cnt = 0; err_pulses = 0; nonseq_cyc = 0; post_err_active = 0;
        min_gap = 99; idle_run = 0; seen_nonseq = 0; seen_err = 0;
        prev_stall = 0; beat_cnt = 0; dp_beat = 0;
        stall_beat = 0; stall_left = 0; err_beat = 0; err_phase = 0;
    endtask

    // Slave response for the current cycle, from the data phase in progress.
    task automatic drive_slave();
        Hreadyout = 1'b1;
        Hresp     = 2'b00;
        if (dp_active && dp_beat == err_beat) begin
            // two-cycle ERROR response
            Hresp     = 2'b01;
            Hreadyout = err_phase;
            err_phase = 1'b1;
        end else if (dp_active && dp_beat == stall_beat && stall_left > 0) begin
            Hreadyout = 1'b0;
            stall_left--;
        end
    endtask

    // Sample the bus at the falling edge, then move to just after the next rising edge.
    task automatic clk_cycle();
        bit n_active, n_write, addr_done, was_req;
        logic [31:0] n_addr, n_wdata;
        @(negedge Hclk);
        n_active = dp_active; n_write = dp_write; n_addr = dp_addr; n_wdata = dp_wdata;
        addr_done = 0;
        if (Htrans == 2'b01) trans_busy_cnt++;
        if (Htrans != 2'b00 && !busy) busy_viol++;
        if (Htrans == 2'b10) begin
            nonseq_cyc++;
            if (seen_nonseq && idle_run < min_gap) min_gap = idle_run;
            seen_nonseq = 1;
        end
        idle_run = (Htrans == 2'b00) ? idle_run + 1 : 0;
        if (seen_err && Htrans != 2'b00) post_err_active++;
        if (err) begin err_pulses++; seen_err = 1; end
        if (rd_valid) rd_q.push_back(rd_data);
        was_req = wdata_req;
        if (wdata_req) wreq_cnt++;
        if (prev_stall) begin
            check("hold_haddr", Haddr, prev_addr);
            check("hold_htrans", 32'(Htrans), 32'(prev_trans));
            check("hold_hwdata", Hwdata, prev_wdata);
        end
        if (dp_active && dp_write) check("hwdata", Hwdata, dp_wdata);
        busy_s = busy;
        acc_s  = cmd_valid && cmd_ready;
        if (Hreadyout) begin
            n_active = Htrans[1];
            if (Htrans[1]) begin
                addr_done = 1;
                n_addr  = Haddr;
                n_write = Hwrite;
                n_wdata = wdata_in;
                addr_q.push_back(Haddr);
                trans_q.push_back(Htrans);
            end
        end
        prev_stall = Htrans[1] && !Hreadyout && (Hresp == 2'b00);
        prev_addr  = Haddr;
        prev_trans = Htrans;
        prev_wdata = Hwdata;
        @(posedge Hclk);
        #1;
        dp_active = n_active; dp_write = n_write; dp_addr = n_addr; dp_wdata = n_wdata;
        if (addr_done) begin beat_cnt++; dp_beat = beat_cnt; end
        if (was_req) wdata_in = wdata_in + 32'h1111_1111;
    endtask

    task automatic wait_accept();
        int n = 0;
        acc_s = 0;
        while (!acc_s && n < 20) begin drive_slave(); clk_cycle(); n++; end
        cmd_valid = 1'b0;
        if (!acc_s) check("accept_timeout", 0, 1);
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin drive_slave(); clk_cycle(); n++; end while (busy_s && n < 40);
        if (busy_s) check("idle_timeout", 0, 1);
    endtask

    task automatic run_cmd(input bit wr, input logic [31:0] addr, input logic [1:0] len);
        cmd_write = wr; cmd_addr = addr; cmd_len = len; cmd_valid = 1'b1;
        wait_accept();
        wait_idle();
        $display("cmd wr=%0d addr=%h len=%0d addr_beats=%0d rd_beats=%0d wreq=%0d err=%0d",
                 wr, addr, len, addr_q.size(), rd_q.size(), wreq_cnt, err_pulses);
    endtask

    initial begin
        int n;
        Hresetn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 32'd0; cmd_len = 2'd0;
        wdata_in = 32'd0; Hreadyout = 1'b1; Hresp = 2'b00;
        dp_active = 0; dp_write = 0; dp_addr = 32'd0; dp_wdata = 32'd0;
        clear_mon();
        repeat (2) @(posedge Hclk);
        #1;

        // reset values
        check("rst_htrans", 32'(Htrans), 0);
        check("rst_haddr", Haddr, 0);
        check("rst_hwrite", 32'(Hwrite), 0);
        check("rst_hwdata", Hwdata, 0);
        check("rst_rd_data", rd_data, 0);
        check("rst_cmd_ready", 32'(cmd_ready), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_rd_valid", 32'(rd_valid), 0);
        check("rst_err", 32'(err), 0);
        check("rst_wdata_req", 32'(wdata_req), 0);
        Hresetn = 1'b1;
        #1;
        check("rel_cmd_ready_pre", 32'(cmd_ready), 0);
        clk_cycle();
        check("rel_cmd_ready_edge", 32'(cmd_ready), 1);
        $display("reset released");

        // single write
        clear_mon();
        wdata_in = 32'hA5A5_A5A5;
        run_cmd(1'b1, 32'h8000_0000, 2'd0);
        check("a_beats", addr_q.size(), 1);
        check("a_addr", addr_at(0), 32'h8000_0000);
        check("a_trans", trans_at(0), 32'h2);
        check("a_nonseq_cyc", nonseq_cyc, 1);
        check("a_wreq", wreq_cnt, 1);
        check("a_err", err_pulses, 0);

        // 4-beat read with a 2-cycle wait on beat 2
        clear_mon();
        stall_beat = 2; stall_left = 2;
        run_cmd(1'b0, 32'h8400_0000, 2'd3);
        check("b_beats", addr_q.size(), 4);
        for (int i = 0; i < 4; i++) begin
            check("b_addr", addr_at(i), 32'h8400_0000 + 32'(4 * i));
            check("b_trans", trans_at(i), (i == 0) ? 32'h2 : 32'h3);
            check("b_rd", rd_at(i), (32'h8400_0000 + 32'(4 * i)) ^ 32'h5A5A_0000);
        end
        check("b_rd_cnt", rd_q.size(), 4);
        check("b_stall_used", stall_left, 0);

        // write burst with ERROR on beat 2
        clear_mon();
        err_beat = 2;
        wdata_in = 32'h1000_0001;
        run_cmd(1'b1, 32'h8800_0000, 2'd3);
        check("c_err_pulses", err_pulses, 1);
        check("c_beats", addr_q.size(), 2);
        check("c_addr0", addr_at(0), 32'h8800_0000);
        check("c_addr1", addr_at(1), 32'h8800_0004);
        check("c_wreq", wreq_cnt, 2);
        check("c_post_err", post_err_active, 0);
        check("c_rd", rd_q.size(), 0);

        // address wrap
        clear_mon();
        run_cmd(1'b0, 32'hFFFF_FFFC, 2'd1);
        check("e_beats", addr_q.size(), 2);
        check("e_addr0", addr_at(0), 32'hFFFF_FFFC);
        check("e_addr1", addr_at(1), 32'h0000_0000);
        check("e_rd0", rd_at(0), 32'hA5A5_FFFC);
        check("e_rd1", rd_at(1), 32'h5A5A_0000);

        // back-to-back single reads, cmd_valid held
        clear_mon();
        cmd_write = 1'b0; cmd_addr = 32'h8000_0010; cmd_len = 2'd0; cmd_valid = 1'b1;
        n = 0;
        begin
            int accs = 0;
            while (accs < 2 && n < 30) begin
                drive_slave(); clk_cycle(); n++;
                if (acc_s) begin accs++; cmd_addr = 32'h8000_0014; end
            end
            cmd_valid = 1'b0;
            if (accs < 2) check("f_accept_timeout", 0, 1);
        end
        wait_idle();
        $display("b2b reads addr_beats=%0d rd_beats=%0d min_gap=%0d", addr_q.size(), rd_q.size(), min_gap);
        check("f_nonseq_cyc", nonseq_cyc, 2);
        check("f_gap", 32'(min_gap >= 1), 1);
        check("f_addr0", addr_at(0), 32'h8000_0010);
        check("f_addr1", addr_at(1), 32'h8000_0014);
        check("f_rd0", rd_at(0), 32'hDA5A_0010);
        check("f_rd1", rd_at(1), 32'hDA5A_0014);

        // reset during beat 3 of a 4-beat read
        clear_mon();
        cmd_write = 1'b0; cmd_addr = 32'h8C00_0000; cmd_len = 2'd3; cmd_valid = 1'b1;
        wait_accept();
        n = 0;
        while (addr_q.size() < 2 && n < 20) begin drive_slave(); clk_cycle(); n++; end
        if (addr_q.size() < 2) check("d_timeout", 0, 1);
        check("d_haddr_pre", Haddr, 32'h8C00_0008);
        Hresetn = 1'b0;
        #1;
        check("d_htrans", 32'(Htrans), 0);
        check("d_haddr", Haddr, 0);
        check("d_busy", 32'(busy), 0);
        check("d_cmd_ready", 32'(cmd_ready), 0);
        check("d_rd_valid", 32'(rd_valid), 0);
        check("d_wdata_req", 32'(wdata_req), 0);
        check("d_err", 32'(err), 0);
        dp_active = 0; prev_stall = 0;
        repeat (2) clk_cycle();
        Hresetn = 1'b1;
        #1;
        check("d_cmd_ready_rel", 32'(cmd_ready), 0);
        clk_cycle();
        check("d_cmd_ready_edge", 32'(cmd_ready), 1);
        check("d_rd_cnt", rd_q.size(), 0);
        check("d_err_cnt", err_pulses, 0);
        $display("reset mid-burst done");

        check("no_htrans_busy", trans_busy_cnt, 0);
        check("busy_during_xfer", busy_viol, 0);

        $display("Result: errors=%0d of %0d checks", fail_cnt, check_cnt);
        $finish;
    end

endmodule
